// File: rtl/crash_pkg.sv
// Shared constants and encodings for the sequential flappy-bird crash checker.
package crash_pkg;

    // Default geometry, in pixels
    localparam int DEF_NUM_PILLARS   = 3;
    localparam int DEF_COORD_W       = 10;
    localparam int DEF_BIRD_X        = 80;
    localparam int DEF_BIRD_HALF_H   = 6;
    localparam int DEF_BIRD_HALF_W   = 15;
    localparam int DEF_PILLAR_HALF_W = 30;
    localparam int DEF_GAP_HALF      = 35;
    localparam int DEF_SCREEN_H      = 480;

    // What the bird collided with
    typedef enum logic [1:0] {
        HIT_NONE   = 2'd0,
        HIT_PILLAR = 2'd1,
        HIT_TOP    = 2'd2,
        HIT_BOTTOM = 2'd3
    } hit_kind_e;

    // Check sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BOUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pillar_hit_cmp.sv
// Combinational collision test of the bird against a single pillar.
// All comparisons are done on zero-extended sums so nothing can underflow
// when a pillar sits near the left edge or its gap near the top of the screen.
module pillar_hit_cmp
    import crash_pkg::*;
#(
    parameter int COORD_W       = DEF_COORD_W,
    parameter int BIRD_X        = DEF_BIRD_X,
    parameter int BIRD_HALF_H   = DEF_BIRD_HALF_H,
    parameter int BIRD_HALF_W   = DEF_BIRD_HALF_W,
    parameter int PILLAR_HALF_W = DEF_PILLAR_HALF_W,
    parameter int GAP_HALF      = DEF_GAP_HALF
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] bird_y,
    output logic               hit
);

    localparam int SUM_W = COORD_W + 2;

    localparam logic [SUM_W-1:0] X_RIGHT_LIM = SUM_W'(BIRD_X + BIRD_HALF_W + PILLAR_HALF_W);
    localparam logic [SUM_W-1:0] X_BIRD      = SUM_W'(BIRD_X);
    localparam logic [SUM_W-1:0] X_REACH     = SUM_W'(PILLAR_HALF_W + BIRD_HALF_W);
    localparam logic [SUM_W-1:0] GAP_E       = SUM_W'(GAP_HALF);
    localparam logic [SUM_W-1:0] BIRD_H_E    = SUM_W'(BIRD_HALF_H);

    logic [SUM_W-1:0] px_e;
    logic [SUM_W-1:0] py_e;
    logic [SUM_W-1:0] by_e;
    logic             h_overlap;
    logic             above_gap;
    logic             below_gap;

    // Horizontal overlap and vertical escape from the gap, rearranged to avoid subtraction
    always_comb begin
        px_e      = {2'b00, px};
        py_e      = {2'b00, py};
        by_e      = {2'b00, bird_y};
        h_overlap = (px_e <= X_RIGHT_LIM) && (X_BIRD <= (px_e + X_REACH));
        above_gap = (by_e + GAP_E) < (py_e + BIRD_H_E);
        below_gap = (by_e + BIRD_H_E) > (py_e + GAP_E);
        hit       = h_overlap && (above_gap || below_gap);
    end

endmodule

// File: rtl/crash_detect_seq.sv
// Sequential collision checker: snapshots bird and pillar positions on a
// frame tick, scans one pillar per clock through a single comparator, then
// checks the screen limits and latches a sticky game_over with the hit cause.
module crash_detect_seq
    import crash_pkg::*;
#(
    parameter int NUM_PILLARS   = DEF_NUM_PILLARS,
    parameter int COORD_W       = DEF_COORD_W,
    parameter int BIRD_X        = DEF_BIRD_X,
    parameter int BIRD_HALF_H   = DEF_BIRD_HALF_H,
    parameter int BIRD_HALF_W   = DEF_BIRD_HALF_W,
    parameter int PILLAR_HALF_W = DEF_PILLAR_HALF_W,
    parameter int GAP_HALF      = DEF_GAP_HALF,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    localparam int IDX_W        = (NUM_PILLARS > 1) ? $clog2(NUM_PILLARS) : 1
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           enable,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             bird_y,
    input  logic [NUM_PILLARS*COORD_W-1:0] pillar_x,
    input  logic [NUM_PILLARS*COORD_W-1:0] pillar_y,
    output logic                           busy,
    output logic                           check_done,
    output logic                           game_over,
    output logic [1:0]                     hit_kind,
    output logic [IDX_W-1:0]               hit_idx,
    output logic                           overrun
);

    localparam int SUM_W = COORD_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PILLARS - 1);
    localparam logic [SUM_W-1:0] TOP_LIM   = SUM_W'(BIRD_HALF_H);
    localparam logic [SUM_W-1:0] BIRD_H_E  = SUM_W'(BIRD_HALF_H);
    localparam logic [SUM_W-1:0] BOT_LIM   = SUM_W'(SCREEN_H);

    logic [COORD_W-1:0] px_in [NUM_PILLARS];
    logic [COORD_W-1:0] py_in [NUM_PILLARS];

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [COORD_W-1:0] bird_q,      bird_d;
    logic [COORD_W-1:0] px_q [NUM_PILLARS];
    logic [COORD_W-1:0] px_d [NUM_PILLARS];
    logic [COORD_W-1:0] py_q [NUM_PILLARS];
    logic [COORD_W-1:0] py_d [NUM_PILLARS];
    logic               pil_hit_q,   pil_hit_d;
    logic [IDX_W-1:0]   pil_idx_q,   pil_idx_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         hit_kind_q,  hit_kind_d;
    logic [IDX_W-1:0]   hit_idx_q,   hit_idx_d;
    logic               overrun_q,   overrun_d;

    logic [COORD_W-1:0] cmp_px;
    logic [COORD_W-1:0] cmp_py;
    logic               cmp_hit;
    logic [SUM_W-1:0]   by_e;
    logic               top_hit;
    logic               bot_hit;

    // Split the packed pillar buses into per-pillar coordinates
    generate
        for (genvar gi = 0; gi < NUM_PILLARS; gi++) begin : g_unpack
            assign px_in[gi] = pillar_x[gi*COORD_W +: COORD_W];
            assign py_in[gi] = pillar_y[gi*COORD_W +: COORD_W];
        end
    endgenerate

    // The pillar currently being scanned is picked from the snapshot
    assign cmp_px = px_q[idx_q];
    assign cmp_py = py_q[idx_q];

    pillar_hit_cmp #(
        .COORD_W       (COORD_W),
        .BIRD_X        (BIRD_X),
        .BIRD_HALF_H   (BIRD_HALF_H),
        .BIRD_HALF_W   (BIRD_HALF_W),
        .PILLAR_HALF_W (PILLAR_HALF_W),
        .GAP_HALF      (GAP_HALF)
    ) u_cmp (
        .px     (cmp_px),
        .py     (cmp_py),
        .bird_y (bird_q),
        .hit    (cmp_hit)
    );

    // Screen limits, evaluated on the snapshot bird position
    always_comb begin
        by_e    = {2'b00, bird_q};
        top_hit = by_e <= TOP_LIM;
        bot_hit = (by_e + BIRD_H_E) >= BOT_LIM;
    end

    // Sequencer next-state, snapshot capture and result latching
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bird_d      = bird_q;
        px_d        = px_q;
        py_d        = py_q;
        pil_hit_d   = pil_hit_q;
        pil_idx_d   = pil_idx_q;
        game_over_d = game_over_q;
        hit_kind_d  = hit_kind_q;
        hit_idx_d   = hit_idx_q;
        overrun_d   = overrun_q;

        // A live tick while a check is still in flight gets dropped and flagged
        if (frame_tick && enable && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && enable && !game_over_q) begin
                    state_d   = ST_SCAN;
                    idx_d     = '0;
                    bird_d    = bird_y;
                    px_d      = px_in;
                    py_d      = py_in;
                    pil_hit_d = 1'b0;
                    pil_idx_d = '0;
                end
            end
            ST_SCAN: begin
                // Keep only the lowest-index hit; scanning always runs to the end
                if (cmp_hit && !pil_hit_q) begin
                    pil_hit_d = 1'b1;
                    pil_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_BOUND;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_BOUND: begin
                // Commit so the result is visible together with check_done
                state_d = ST_DONE;
                if (pil_hit_q) begin
                    game_over_d = 1'b1;
                    hit_kind_d  = HIT_PILLAR;
                    hit_idx_d   = pil_idx_q;
                end else if (top_hit) begin
                    game_over_d = 1'b1;
                    hit_kind_d  = HIT_TOP;
                end else if (bot_hit) begin
                    game_over_d = 1'b1;
                    hit_kind_d  = HIT_BOTTOM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bird_q      <= '0;
            for (int i = 0; i < NUM_PILLARS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
            pil_hit_q   <= 1'b0;
            pil_idx_q   <= '0;
            game_over_q <= 1'b0;
            hit_kind_q  <= HIT_NONE;
            hit_idx_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bird_q      <= bird_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pil_hit_q   <= pil_hit_d;
            pil_idx_q   <= pil_idx_d;
            game_over_q <= game_over_d;
            hit_kind_q  <= hit_kind_d;
            hit_idx_q   <= hit_idx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy       = (state_q == ST_SCAN) || (state_q == ST_BOUND);
    assign check_done = (state_q == ST_DONE);
    assign game_over  = game_over_q;
    assign hit_kind   = hit_kind_q;
    assign hit_idx    = hit_idx_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_crash_detect_seq.sv
// Bench for crash_detect_seq: directed cases on a 3-pillar instance and
// randomized frames on a 5-pillar instance, both against a behavioural model.
module tb_crash_detect_seq;

    localparam int CW = 10;
    localparam int BX = 80;
    localparam int BH = 6;
    localparam int BW = 15;
    localparam int PW = 30;
    localparam int GH = 35;
    localparam int SH = 480;

    logic clk = 1'b0;
    logic clr;

    logic            en3, tick3;
    logic [CW-1:0]   bird3;
    logic [3*CW-1:0] px3, py3;
    logic            busy3, done3, go3, ovr3;
    logic [1:0]      kind3;
    logic [1:0]      idx3;

    logic            en5, tick5;
    logic [CW-1:0]   bird5;
    logic [5*CW-1:0] px5, py5;
    logic            busy5, done5, go5, ovr5;
    logic [1:0]      kind5;
    logic [2:0]      idx5;

    int n_checks = 0;
    int n_fail   = 0;

    int cur_by;
    int cur_x [5];
    int cur_y [5];

    always #5 clk = ~clk;

    crash_detect_seq #(.NUM_PILLARS(3)) dut3 (
        .clk(clk), .clr(clr), .enable(en3), .frame_tick(tick3), .bird_y(bird3),
        .pillar_x(px3), .pillar_y(py3), .busy(busy3), .check_done(done3),
        .game_over(go3), .hit_kind(kind3), .hit_idx(idx3), .overrun(ovr3)
    );

    crash_detect_seq #(.NUM_PILLARS(5)) dut5 (
        .clk(clk), .clr(clr), .enable(en5), .frame_tick(tick5), .bird_y(bird5),
        .pillar_x(px5), .pillar_y(py5), .busy(busy5), .check_done(done5),
        .game_over(go5), .hit_kind(kind5), .hit_idx(idx5), .overrun(ovr5)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Collision rules in plain integer arithmetic: first pillar hit wins, then top, then bottom
    function automatic void ref_model(input int by, input int xs[5], input int ys[5], input int n,
                                      output int kind, output int idx);
        bit hov;
        bit outside;
        kind = 0;
        idx  = 0;
        for (int i = 0; i < n; i++) begin
            hov     = (xs[i] <= BX + BW + PW) && (BX <= xs[i] + PW + BW);
            outside = (by + GH < ys[i] + BH) || (by + BH > ys[i] + GH);
            if (hov && outside) begin
                kind = 1;
                idx  = i;
                return;
            end
        end
        if (by <= BH)            kind = 2;
        else if (by + BH >= SH)  kind = 3;
    endfunction

    task automatic set3(input int by, input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2);
        cur_by = by;
        cur_x  = '{x0, x1, x2, 0, 0};
        cur_y  = '{y0, y1, y2, 0, 0};
        bird3  = CW'(by);
        px3    = {CW'(x2), CW'(x1), CW'(x0)};
        py3    = {CW'(y2), CW'(y1), CW'(y0)};
    endtask

    task automatic apply5(input int by, input int xs[5], input int ys[5]);
        bird5 = CW'(by);
        for (int i = 0; i < 5; i++) begin
            px5[i*CW +: CW] = CW'(xs[i]);
            py5[i*CW +: CW] = CW'(ys[i]);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Pulse a tick into dut3 and watch a bounded window.
    // lat = number of rising edges from the tick edge to the edge that samples check_done high.
    task automatic run3(output int lat, output int busy_cnt, output int done_cnt);
        lat = -1; busy_cnt = 0; done_cnt = 0;
        tick3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (busy3) busy_cnt++;
            if (done3) begin
                done_cnt++;
                if (lat < 0) lat = k + 1;
            end
            @(negedge clk);
        end
    endtask

    // Directed result check of dut3 against the model for the current inputs
    task automatic chk_model3(input string tag);
        int ek, ei;
        ref_model(cur_by, cur_x, cur_y, 3, ek, ei);
        chk({tag, "_kind"}, kind3, ek);
        chk({tag, "_go"}, go3, (ek != 0) ? 1 : 0);
        if (ek == 1) chk({tag, "_idx"}, idx3, ei);
    endtask

    initial begin
        int lat, bc, dc, ek, ei, tmp, by;
        int xs [5];
        int ys [5];

        clr = 1'b1; en3 = 1'b1; tick3 = 1'b0; en5 = 1'b1; tick5 = 1'b0;
        set3(0, 0, 0, 0, 0, 0, 0);
        bird5 = '0; px5 = '0; py5 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_go", go3, 0);
        chk("rst_kind", kind3, 0);
        chk("rst_idx", idx3, 0);
        chk("rst_ovr", ovr3, 0);
        clr = 1'b0;
        @(negedge clk);

        // Clear flight through the middle of three gaps
        set3(240, 300, 240, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t1_lat", lat, 5);
        chk("t1_busy_cycles", bc, 4);
        chk("t1_done_count", dc, 1);
        chk("t1_kind", kind3, 0);
        chk_model3("t1");

        // Bird above the gap of pillar 1
        set3(200, 300, 240, 80, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t2_go", go3, 1);
        chk("t2_kind", kind3, 1);
        chk("t2_idx", idx3, 1);
        chk_model3("t2");
        run3(lat, bc, dc);
        chk("t2_after_go_done", dc, 0);
        chk("t2_after_go_busy", bc, 0);

        // Screen boundaries
        do_clr();
        set3(476, 300, 240, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t3_bottom", kind3, 3);
        chk_model3("t3b");
        do_clr();
        set3(6, 300, 240, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t3_top", kind3, 2);
        do_clr();
        set3(7, 300, 240, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t3_none_kind", kind3, 0);
        chk("t3_none_go", go3, 0);

        // Pillar hugging the left edge with gap at y=0: bird horizontally clear of it, top wins
        do_clr();
        set3(3, 20, 0, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t4a_kind", kind3, 2);
        chk_model3("t4a");
        // Overlapping pillar above-gap hit outranks the top boundary
        do_clr();
        set3(3, 80, 100, 450, 240, 600, 240);
        run3(lat, bc, dc);
        chk("t4b_kind", kind3, 1);
        chk("t4b_idx", idx3, 0);
        chk_model3("t4b");

        // Enable low: tick ignored, no overrun
        do_clr();
        en3 = 1'b0;
        set3(200, 300, 240, 80, 240, 600, 240);
        run3(lat, bc, dc);
        chk("en_low_done", dc, 0);
        chk("en_low_ovr", ovr3, 0);
        chk("en_low_go", go3, 0);
        en3 = 1'b1;

        // Second tick two edges after the first
        do_clr();
        set3(240, 300, 240, 450, 240, 600, 240);
        tick3 = 1'b1; @(posedge clk); @(negedge clk); tick3 = 1'b0;
        @(negedge clk);
        tick3 = 1'b1; @(negedge clk); tick3 = 1'b0;
        chk("t5_ovr", ovr3, 1);
        dc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done3) dc++;
            @(negedge clk);
        end
        chk("t5_done_count", dc, 1);
        chk("t5_ovr_sticky", ovr3, 1);

        // Clear in the middle of a scan that would otherwise crash
        do_clr();
        set3(200, 300, 240, 80, 240, 600, 240);
        tick3 = 1'b1; @(posedge clk); @(negedge clk); tick3 = 1'b0;
        @(negedge clk);
        tick3 = 1'b1; @(negedge clk); tick3 = 1'b0;
        chk("t5c_ovr_before", ovr3, 1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        chk("t5c_busy", busy3, 0);
        chk("t5c_ovr", ovr3, 0);
        chk("t5c_go", go3, 0);
        chk("t5c_kind", kind3, 0);
        dc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done3) dc++;
            @(negedge clk);
        end
        chk("t5c_done_count", dc, 0);
        chk("t5c_go_after", go3, 0);

        // Randomized frames on the 5-pillar instance, scrambling live inputs mid-scan
        for (int it = 0; it < 40; it++) begin
            do_clr();
            case (it % 4)
                0:       by = $urandom_range(0, 10);
                1:       by = $urandom_range(466, 520);
                default: by = $urandom_range(0, 520);
            endcase
            for (int i = 0; i < 5; i++) begin
                xs[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 220) : $urandom_range(130, 1023);
                if ($urandom_range(0, 1) == 0) begin
                    tmp   = $urandom_range(0, 58);
                    ys[i] = by + tmp - 29;
                    if (ys[i] < 0) ys[i] = 0;
                end else begin
                    ys[i] = $urandom_range(0, 480);
                end
            end
            apply5(by, xs, ys);
            ref_model(by, xs, ys, 5, ek, ei);
            tick5 = 1'b1; @(posedge clk); @(negedge clk); tick5 = 1'b0;
            lat = -1; dc = 0;
            for (int k = 0; k < 12; k++) begin
                if (done5) begin
                    dc++;
                    if (lat < 0) lat = k + 1;
                end
                for (int i = 0; i < 5; i++) begin
                    xs[i] = $urandom_range(0, 1023);
                    ys[i] = $urandom_range(0, 1023);
                end
                apply5($urandom_range(0, 1023), xs, ys);
                @(negedge clk);
            end
            $display("rand it=%0d by=%0d exp_kind=%0d exp_idx=%0d", it, by, ek, ei);
            chk("r_lat", lat, 7);
            chk("r_done_count", dc, 1);
            chk("r_kind", kind5, ek);
            chk("r_go", go5, (ek != 0) ? 1 : 0);
            if (ek == 1) chk("r_idx", idx5, ei);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
